// File: rtl/dcache_filler.sv
// rtl/dcache_filler.sv - byte-serial load filler with optional aligned-word d-cache refill
// Optional refill path enabled by DCACHE_REFILL_EN.
module dcache_filler (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_type,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_din,
    output logic        cache_write_bit,
    output logic [2:0]  cache_write_type,
    output logic [31:0] cache_write_addr,
    output logic [7:0]  cache_write_data
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  type_q, type_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic [31:0] resp_q, resp_d;
    logic [2:0]  nbytes;
    logic [1:0]  cap_idx;
    logic        issue;
    logic        capture;

    always_comb begin
        case (type_q)
            3'b000, 3'b100: nbytes = 3'd1;
            3'b001, 3'b101: nbytes = 3'd2;
            default:        nbytes = 3'd4;
        endcase
    end

    // cnt_q counts READ cycles: it issues byte cnt_q and captures byte cnt_q-1.
    assign cap_idx = 2'(cnt_q - 3'd1);
    assign issue   = !rst && (state_q == S_READ) && (cnt_q < nbytes);
    assign capture = !rst && (state_q == S_READ) && (cnt_q != 3'd0);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        type_d   = type_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        resp_d   = resp_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    type_d   = req_type;
                    cnt_d    = 3'd0;
                    result_d = 32'd0;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q != 3'd0) begin
                    result_d[{cap_idx, 3'b000} +: 8] = mem_din;
                end
                if (cnt_q == nbytes) begin
                    state_d = S_DONE;
                    case (type_q)
                        3'b000:  resp_d = {{24{result_d[7]}}, result_d[7:0]};
                        3'b100:  resp_d = {24'd0, result_d[7:0]};
                        3'b001:  resp_d = {{16{result_d[15]}}, result_d[15:0]};
                        3'b101:  resp_d = {16'd0, result_d[15:0]};
                        default: resp_d = result_d;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            type_q   <= 3'd0;
            cnt_q    <= 3'd0;
            result_q <= 32'd0;
            resp_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            type_q   <= type_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            resp_q   <= resp_d;
        end
    end

    assign req_ready  = !rst && (state_q == S_IDLE);
    assign resp_valid = !rst && (state_q == S_DONE);
    assign resp_data  = resp_q;
    assign mem_rd_en  = issue;
    assign mem_addr   = issue ? (addr_q + 32'(cnt_q)) : 32'd0;

`ifdef DCACHE_REFILL_EN
    logic refill_ok;
    // Only aligned, non-IO word loads are worth installing in the cache.
    assign refill_ok        = (type_q == 3'b010) && (addr_q[1:0] == 2'b00) && (addr_q[17:16] != 2'b11);
    assign cache_write_bit  = capture && refill_ok;
    assign cache_write_type = cache_write_bit ? 3'b010 : 3'b000;
    assign cache_write_addr = cache_write_bit ? (addr_q + 32'(cap_idx)) : 32'd0;
    assign cache_write_data = cache_write_bit ? mem_din : 8'd0;
`else
    assign cache_write_bit  = 1'b0;
    assign cache_write_type = 3'b000;
    assign cache_write_addr = 32'd0;
    assign cache_write_data = 8'd0;
`endif
endmodule

// File: tb/tb_dcache_filler.sv
// tb/tb_dcache_filler.sv - scoreboard bench for dcache_filler against a byte-memory reference model
module tb_dcache_filler;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [2:0]  req_type;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_din;
    logic        cache_write_bit;
    logic [2:0]  cache_write_type;
    logic [31:0] cache_write_addr;
    logic [7:0]  cache_write_data;

    dcache_filler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_type(req_type), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_din(mem_din),
        .cache_write_bit(cache_write_bit), .cache_write_type(cache_write_type),
        .cache_write_addr(cache_write_addr), .cache_write_data(cache_write_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; int cyc; } resp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } cw_t;
    resp_t       resp_q[$];
    logic [31:0] rd_q[$];
    cw_t         cw_q[$];
    logic [7:0]  mem [logic [31:0]];
    logic [31:0] last_resp = 32'd0;
    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ (a[15:8] * 8'd7) ^ a[31:24] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_din <= rd(mem_addr);
        else           mem_din <= 8'($urandom);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) begin
                if (rd_q.size() == 0) check("unexpected_mem_rd", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                else check("mem_addr", 64'(mem_addr), 64'(rd_q.pop_front()));
            end
            if (cache_write_bit) begin
                if (cw_q.size() == 0) check("unexpected_cache_write", 64'(cache_write_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    cw_t c;
                    c = cw_q.pop_front();
                    check("cw_addr", 64'(cache_write_addr), 64'(c.a));
                    check("cw_data", 64'(cache_write_data), 64'(c.d));
                    check("cw_type", 64'(cache_write_type), 64'(3'b010));
                end
            end else begin
                check("cw_idle_zero", 64'({cache_write_type, cache_write_addr, cache_write_data}), 64'd0);
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) check("unexpected_resp", 64'(resp_data), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check("resp_data", 64'(resp_data), 64'(r.data));
                    check("resp_cycle", 64'(cyc), 64'(r.cyc));
                    last_resp = r.data;
                end
            end else begin
                check("resp_hold", 64'(resp_data), 64'(last_resp));
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [2:0] t, input bit garbage);
        int n, guard, acc;
        logic [31:0] word, exp_v;
        bit refill;
        resp_t r;
        cw_t c;
        n = (t == 3'b000 || t == 3'b100) ? 1 : (t == 3'b001 || t == 3'b101) ? 2 : 4;
        word = 32'd0;
        for (int k = 0; k < n; k++) word = word | (32'(rd(a + 32'(k))) << (8 * k));
        case (t)
            3'b000:  exp_v = 32'($signed(word[7:0]));
            3'b100:  exp_v = 32'(word[7:0]);
            3'b001:  exp_v = 32'($signed(word[15:0]));
            3'b101:  exp_v = 32'(word[15:0]);
            default: exp_v = word;
        endcase
`ifdef DCACHE_REFILL_EN
        refill = (t == 3'b010) && (a % 4 == 0) && (((a >> 16) & 3) != 3);
`else
        refill = 1'b0;
`endif
        req_valid = 1'b1; req_addr = a; req_type = t;
        #1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!req_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc;
        for (int k = 0; k < n; k++) begin
            rd_q.push_back(a + 32'(k));
            if (refill) begin
                c.a = a + 32'(k); c.d = rd(a + 32'(k));
                cw_q.push_back(c);
            end
        end
        r.data = exp_v; r.cyc = acc + n + 2;
        resp_q.push_back(r);
        @(posedge clk); #1;
        for (int j = 0; j < n + 1; j++) begin
            req_valid = garbage ? 1'($urandom) : 1'b0;
            req_addr  = $urandom;
            req_type  = 3'($urandom);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int guard;
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_type = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({req_ready, resp_valid, resp_data, mem_rd_en}), 64'd0);
        check("reset_outputs2", 64'({mem_addr, cache_write_bit, cache_write_type, cache_write_data}), 64'd0);
        check("reset_cw_addr", 64'(cache_write_addr), 64'd0);
        rst = 1'b0;

        mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
        do_req(32'h0000_0100, 3'b010, 1'b0);
        mem[32'h203] = 8'h80;
        do_req(32'h0000_0203, 3'b000, 1'b1);
        do_req(32'h0000_0203, 3'b100, 1'b0);
        mem[32'h10] = 8'hFE; mem[32'h11] = 8'hFF;
        do_req(32'h0000_0010, 3'b001, 1'b1);
        do_req(32'h0000_0010, 3'b101, 1'b0);
        do_req(32'h0003_0000, 3'b010, 1'b0);
        do_req(32'h0000_0102, 3'b010, 1'b1);
        do_req(32'hFFFF_FFFE, 3'b010, 1'b0);

        // Reset three cycles into an LW: partial work must vanish.
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 32'h0000_0400; req_type = 3'b010;
        #1;
        check("ready_before_reset_lw", 64'(req_ready), 64'd1);
        for (int k = 0; k < 4; k++) rd_q.push_back(32'h400 + 32'(k));
`ifdef DCACHE_REFILL_EN
        for (int k = 0; k < 4; k++) begin
            cw_t c;
            c.a = 32'h400 + 32'(k); c.d = rd(32'h400 + 32'(k));
            cw_q.push_back(c);
        end
`endif
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midreset_outputs", 64'({req_ready, resp_valid, resp_data, mem_rd_en}), 64'd0);
        check("midreset_outputs2", 64'({mem_addr, cache_write_bit, cache_write_type, cache_write_data}), 64'd0);
        check("midreset_cw_addr", 64'(cache_write_addr), 64'd0);
        rd_q.delete(); cw_q.delete(); resp_q.delete();
        last_resp = 32'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        do_req(32'h0000_0100, 3'b010, 1'b0);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = {$urandom_range(0, 65535), 16'h0} | 32'h0003_0000 | 32'($urandom_range(0, 255) * 4);
                2: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                default: a = {$urandom} & 32'hFFFC_FFFC;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            do_req(a, 3'($urandom), 1'($urandom));
        end

        guard = 0;
        while (resp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk); #1;
        check("drain_resp", 64'(resp_q.size()), 64'd0);
        check("drain_rd", 64'(rd_q.size()), 64'd0);
        check("drain_cw", 64'(cw_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
